// File: rtl/fetch_pkg.sv
// Shared fetch definitions: instruction width, default PC width and the
// queue entry layout that decode also uses to unpack fetched instructions.
package fetch_pkg;

   localparam int unsigned INST_W         = 32;
   localparam int unsigned ADDR_W_DEFAULT = 10;

   // One prefetch queue entry: instruction word plus the PC it was read from.
   typedef struct packed {
      logic [INST_W-1:0]         inst;
      logic [ADDR_W_DEFAULT-1:0] pc;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous DEPTH-entry FIFO with a flush that empties it in one edge.
// Ports:
//   clk, rst_n     clock, async active-low reset (storage is cleared too)
//   flush_i        drop all entries and zero the pointers at the next edge
//   push_i/data_i  write one entry (ignored while flushing)
//   pop_i          retire the head entry (ignored when empty)
//   count_o        number of valid entries
//   head_o         head entry, read combinationally from storage
module fetch_fifo #(
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned DATA_W = 42
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    flush_i,
   input  logic                    push_i,
   input  logic [DATA_W-1:0]       data_i,
   input  logic                    pop_i,
   output logic [$clog2(DEPTH):0]  count_o,
   output logic [DATA_W-1:0]       head_o
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              do_push;
   logic              do_pop;

   // Pointer/count next state; a full FIFO still accepts a push when it pops.
   always_comb begin
      do_pop   = pop_i & (count_q != '0);
      do_push  = push_i & ((count_q != CNT_W'(DEPTH)) | do_pop);
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
         if (do_push & ~do_pop)      count_d = count_q + CNT_W'(1);
         else if (do_pop & ~do_push) count_d = count_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage is cleared on reset so the head reads zero until first write.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (do_push && !flush_i) begin
         mem_q[wr_ptr_q] <= data_i;
      end
   end

   assign count_o = count_q;
   assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/inst_fetch_queue.sv
// Instruction fetch stage: sequential PC generation, synchronous imem reads,
// prefetch queue towards decode, and redirect handling with flush/discard.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   fetch_en                   allow new memory requests
//   imem_req/imem_addr         read strobe and word address
//   imem_rdata                 read data, one cycle after imem_req
//   redirect_valid/pc          one-cycle PC redirect from decode
//   out_valid/ready/inst/pc    valid/ready instruction stream to decode
module inst_fetch_queue
   import fetch_pkg::*;
#(
   parameter int unsigned ADDR_W   = ADDR_W_DEFAULT,
   parameter int unsigned DEPTH    = 4,
   parameter int unsigned RESET_PC = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              fetch_en,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic [INST_W-1:0] imem_rdata,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [INST_W-1:0] out_inst,
   output logic [ADDR_W-1:0] out_pc
);

   localparam int unsigned DATA_W = INST_W + ADDR_W;
   localparam int unsigned CNT_W  = $clog2(DEPTH) + 1;
   localparam int unsigned SUM_W  = CNT_W + 1;

   logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
   logic              inflight_q, inflight_d;
   logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;

   logic [CNT_W-1:0]  fifo_count;
   logic [DATA_W-1:0] fifo_head;
   logic              issue;
   logic              rsp_push;
   logic              head_pop;
   logic              has_space;

   // Reserve a slot for the in-flight read so a response never overflows.
   assign has_space = (SUM_W'(fifo_count) + SUM_W'(inflight_q)) < SUM_W'(DEPTH);
   // rst_n gates the strobe so no read is issued while held in reset.
   assign issue     = rst_n & fetch_en & ~redirect_valid & has_space;
   // A response landing in a redirect cycle belongs to the old path.
   assign rsp_push  = inflight_q & ~redirect_valid;
   assign head_pop  = out_valid & out_ready;

   // PC generator and in-flight tracking next state.
   always_comb begin
      fetch_pc_d    = fetch_pc_q;
      inflight_d    = issue;
      inflight_pc_d = inflight_pc_q;
      if (issue) begin
         inflight_pc_d = fetch_pc_q;
         fetch_pc_d    = fetch_pc_q + ADDR_W'(1);
      end
      if (redirect_valid) fetch_pc_d = redirect_pc;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_pc_q    <= ADDR_W'(RESET_PC);
         inflight_q    <= 1'b0;
         inflight_pc_q <= '0;
      end else begin
         fetch_pc_q    <= fetch_pc_d;
         inflight_q    <= inflight_d;
         inflight_pc_q <= inflight_pc_d;
      end
   end

   fetch_fifo #(
      .DEPTH  (DEPTH),
      .DATA_W (DATA_W)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .flush_i (redirect_valid),
      .push_i  (rsp_push),
      .data_i  ({imem_rdata, inflight_pc_q}),
      .pop_i   (head_pop),
      .count_o (fifo_count),
      .head_o  (fifo_head)
   );

   assign imem_req  = issue;
   assign imem_addr = fetch_pc_q;
   assign out_valid = (fifo_count != '0);
   assign out_inst  = fifo_head[DATA_W-1 -: INST_W];
   assign out_pc    = fifo_head[ADDR_W-1:0];

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Bench for inst_fetch_queue: directed vector table, redirect/wrap/reset
// sequences and a randomized run against a queue-based reference model.
module tb_inst_fetch_queue;

   localparam int unsigned ADDR_W = 10;
   localparam int unsigned DEPTH  = 4;
   localparam int unsigned NROWS  = 19;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              fetch_en;
   logic              imem_req;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_rdata;
   logic              redirect_valid;
   logic [ADDR_W-1:0] redirect_pc;
   logic              out_valid;
   logic              out_ready;
   logic [31:0]       out_inst;
   logic [ADDR_W-1:0] out_pc;

   logic [31:0] mem [1024];

   int total = 0;
   int bad   = 0;

   // Reference model: queue of PCs; instruction at pc is pc+100.
   logic [ADDR_W-1:0] mq [$];
   logic [ADDR_W-1:0] m_fpc;
   logic [ADDR_W-1:0] m_infl_pc;
   bit                m_infl;

   bit                obs_valid;
   logic [ADDR_W-1:0] obs_pc;
   logic [31:0]       obs_inst;

   typedef struct {
      bit                fe;
      bit                rdy;
      bit                e_valid;
      logic [ADDR_W-1:0] e_pc;
      bit                e_req;
      logic [ADDR_W-1:0] e_addr;
   } vec_t;

   vec_t vecs [NROWS];

   always #5 clk = ~clk;

   inst_fetch_queue #(
      .ADDR_W   (ADDR_W),
      .DEPTH    (DEPTH),
      .RESET_PC (0)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .fetch_en       (fetch_en),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_rdata     (imem_rdata),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_inst       (out_inst),
      .out_pc         (out_pc)
   );

   // Synchronous memory; garbage on cycles without a request.
   always @(posedge clk) begin
      if (imem_req) imem_rdata <= mem[imem_addr];
      else          imem_rdata <= $urandom();
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit model_req();
      return rst_n && fetch_en && !redirect_valid &&
             ((mq.size() + int'(m_infl)) < int'(DEPTH));
   endfunction

   task automatic model_reset();
      mq.delete();
      m_fpc     = '0;
      m_infl    = 1'b0;
      m_infl_pc = '0;
   endtask

   task automatic model_edge();
      bit req;
      if (!rst_n) begin
         model_reset();
         return;
      end
      req = model_req();
      if (redirect_valid) begin
         mq.delete();
      end else begin
         if (mq.size() != 0 && out_ready) void'(mq.pop_front());
         if (m_infl) mq.push_back(m_infl_pc);
      end
      m_infl = req;
      if (req) m_infl_pc = m_fpc;
      if (redirect_valid) m_fpc = redirect_pc;
      else if (req)       m_fpc = m_fpc + ADDR_W'(1);
   endtask

   // Compare against the model, then advance one clock.
   task automatic tick();
      bit er;
      #1;
      er = model_req();
      check("imem_req", 32'(imem_req), 32'(er));
      if (er) check("imem_addr", 32'(imem_addr), 32'(m_fpc));
      check("out_valid", 32'(out_valid), 32'(mq.size() != 0));
      if (mq.size() != 0) begin
         check("out_pc", 32'(out_pc), 32'(mq[0]));
         check("out_inst", out_inst, 32'(mq[0]) + 32'd100);
      end
      obs_valid = out_valid;
      obs_pc    = out_pc;
      obs_inst  = out_inst;
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   task automatic set_in(input bit fe, input bit rdy, input bit rv, input logic [ADDR_W-1:0] rpc);
      fetch_en       = fe;
      out_ready      = rdy;
      redirect_valid = rv;
      redirect_pc    = rpc;
   endtask

   // Tick until out_valid is seen; returns ticks taken, 0 on timeout.
   task automatic wait_valid(input string name, output int n);
      n = 0;
      for (int k = 1; k <= 12; k++) begin
         tick();
         if (obs_valid) begin
            n = k;
            break;
         end
      end
      if (n == 0) check({name, "_timeout"}, 32'(0), 32'(1));
   endtask

   initial begin
      int n;
      bit saw20;

      for (int k = 0; k < 1024; k++) mem[k] = 32'(k + 100);

      //            fe rdy valid pc req addr
      vecs[0]  = '{1, 1, 0, 0,  1, 0};
      vecs[1]  = '{1, 1, 0, 0,  1, 1};
      vecs[2]  = '{1, 1, 1, 0,  1, 2};
      vecs[3]  = '{1, 1, 1, 1,  1, 3};
      vecs[4]  = '{1, 1, 1, 2,  1, 4};
      vecs[5]  = '{1, 1, 1, 3,  1, 5};
      vecs[6]  = '{1, 0, 1, 4,  1, 6};
      vecs[7]  = '{1, 0, 1, 4,  1, 7};
      vecs[8]  = '{1, 0, 1, 4,  0, 0};
      vecs[9]  = '{1, 1, 1, 4,  0, 0};
      vecs[10] = '{1, 1, 1, 5,  1, 8};
      vecs[11] = '{1, 1, 1, 6,  1, 9};
      vecs[12] = '{1, 1, 1, 7,  1, 10};
      vecs[13] = '{1, 1, 1, 8,  1, 11};
      vecs[14] = '{0, 1, 1, 9,  0, 0};
      vecs[15] = '{0, 1, 1, 10, 0, 0};
      vecs[16] = '{0, 1, 1, 11, 0, 0};
      vecs[17] = '{0, 1, 0, 0,  0, 0};
      vecs[18] = '{1, 1, 0, 0,  1, 12};

      rst_n = 1'b0;
      set_in(1, 1, 0, '0);
      model_reset();
      repeat (3) @(negedge clk);
      #1;
      check("rst_out_valid", 32'(out_valid), 32'(0));
      check("rst_out_inst", out_inst, 32'(0));
      check("rst_out_pc", 32'(out_pc), 32'(0));
      check("rst_imem_req", 32'(imem_req), 32'(0));
      rst_n = 1'b1;

      // Streaming, backpressure, full queue and fetch_en low from reset.
      for (int i = 0; i < int'(NROWS); i++) begin
         set_in(vecs[i].fe, vecs[i].rdy, 0, '0);
         #1;
         check($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(vecs[i].e_valid));
         if (vecs[i].e_valid) begin
            check($sformatf("vec%0d_pc", i), 32'(out_pc), 32'(vecs[i].e_pc));
            check($sformatf("vec%0d_inst", i), out_inst, 32'(vecs[i].e_pc) + 32'd100);
         end
         check($sformatf("vec%0d_req", i), 32'(imem_req), 32'(vecs[i].e_req));
         if (vecs[i].e_req)
            check($sformatf("vec%0d_addr", i), 32'(imem_addr), 32'(vecs[i].e_addr));
         tick();
      end

      // Redirect while the queue is loaded: stale entries vanish, pc 16 in 3 cycles.
      set_in(1, 0, 0, '0);
      repeat (4) tick();
      set_in(1, 0, 1, ADDR_W'(16));
      tick();
      set_in(1, 1, 0, '0);
      wait_valid("redir16", n);
      check("redir16_latency", 32'(n), 32'(3));
      check("redir16_pc", 32'(obs_pc), 32'(16));
      check("redir16_inst", obs_inst, 32'(116));

      // Back-to-back redirects: only the second target is fetched.
      set_in(1, 1, 1, ADDR_W'(20));
      tick();
      set_in(1, 1, 1, ADDR_W'(30));
      tick();
      set_in(1, 1, 0, '0);
      wait_valid("redir30", n);
      check("redir30_latency", 32'(n), 32'(3));
      check("redir30_pc", 32'(obs_pc), 32'(30));
      saw20 = 1'b0;
      for (int k = 0; k < 8; k++) begin
         tick();
         if (obs_valid && obs_pc == ADDR_W'(20)) saw20 = 1'b1;
      end
      check("redir20_never_seen", 32'(saw20), 32'(0));

      // PC wrap-around at the top of the address space.
      set_in(1, 1, 1, ADDR_W'(1022));
      tick();
      set_in(1, 1, 0, '0);
      wait_valid("wrap", n);
      check("wrap_pc0", 32'(obs_pc), 32'(1022));
      check("wrap_inst0", obs_inst, 32'(1122));
      tick();
      check("wrap_pc1", 32'(obs_pc), 32'(1023));
      tick();
      check("wrap_pc2", 32'(obs_pc), 32'(0));
      check("wrap_inst2", obs_inst, 32'(100));
      tick();
      check("wrap_pc3", 32'(obs_pc), 32'(1));

      // Asynchronous reset with a full queue, then clean restart at pc 0.
      set_in(1, 0, 0, '0);
      repeat (6) tick();
      check("full_before_rst", 32'(out_valid), 32'(1));
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      check("midrst_out_valid", 32'(out_valid), 32'(0));
      check("midrst_imem_req", 32'(imem_req), 32'(0));
      @(negedge clk);
      repeat (2) tick();
      rst_n = 1'b1;
      set_in(1, 1, 0, '0);
      wait_valid("restart", n);
      check("restart_latency", 32'(n), 32'(3));
      check("restart_pc", 32'(obs_pc), 32'(0));
      check("restart_inst", obs_inst, 32'(100));

      // Randomized traffic against the model.
      for (int c = 0; c < 3000; c++) begin
         fetch_en       = ($urandom_range(0, 9) < 8);
         out_ready      = ($urandom_range(0, 9) < 6);
         redirect_valid = ($urandom_range(0, 99) < 5);
         if ($urandom_range(0, 1) == 1) redirect_pc = ADDR_W'($urandom_range(1018, 1023));
         else                           redirect_pc = ADDR_W'($urandom());
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
